err_monitor: RTL



---
 rtl/err_monitor.sv | 76 +++++++
 1 files changed

// File: rtl/err_monitor.sv
// err_monitor: sticky error/watchdog monitor capturing the first failure cause and its cycle number.
module err_monitor #(
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 1024,
    parameter int WDW     = 16,
    parameter int CYCW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src_err,
    input  logic              progress,
    input  logic              halt,
    input  logic              clr,
    output logic              err,
    output logic [NSRC:0]     err_vec,
    output logic [CYCW-1:0]   err_cycle,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, ERROR = 2'd2} st_t;
    st_t             st;
    logic [WDW-1:0]  wd_cnt;
    logic [CYCW-1:0] cyc_cnt;
    logic            tmo;
    assign tmo   = st == RUN && !progress && wd_cnt == WDW'(TIMEOUT - 1);
    assign state = st;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= RUN;
            err       <= 1'b0;
            err_vec   <= '0;
            err_cycle <= '0;
            wd_cnt    <= '0;
            cyc_cnt   <= '0;
        end else begin
            if (st != ERROR && cyc_cnt != '1)
                cyc_cnt <= cyc_cnt + 1'b1;
            case (st)
                RUN: begin
                    if (|src_err || tmo) begin
                        st        <= ERROR;
                        err       <= 1'b1;
                        err_vec   <= {tmo, src_err};
                        err_cycle <= cyc_cnt;
                    end else if (halt) begin
                        st     <= HALTED;
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= (progress || clr) ? '0 : wd_cnt + 1'b1;
                    end
                end
                HALTED: begin
                    wd_cnt <= '0;
                    if (|src_err) begin
                        st        <= ERROR;
                        err       <= 1'b1;
                        err_vec   <= {1'b0, src_err};
                        err_cycle <= cyc_cnt;
                    end else if (!halt) begin
                        st <= RUN;
                    end
                end
                ERROR: begin
                    // first failure stays frozen until explicitly cleared
                    if (clr) begin
                        st        <= RUN;
                        err       <= 1'b0;
                        err_vec   <= '0;
                        err_cycle <= '0;
                        wd_cnt    <= '0;
                    end
                end
                default: st <= RUN;
            endcase
        end
    end
endmodule
